// File: rtl/spi_pkg.sv
// Shared SPI receiver types: FSM state encoding and SPI mode constants.
// Mode number is {CPOL, CPHA}; the helper maps it to the sampling SCK edge.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SPI_MODE0 = 0;
    localparam int SPI_MODE1 = 1;
    localparam int SPI_MODE2 = 2;
    localparam int SPI_MODE3 = 3;

    function automatic logic mode_samples_rise(input int mode);
        case (mode)
            SPI_MODE0, SPI_MODE3: return 1'b1;
            SPI_MODE1, SPI_MODE2: return 1'b0;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous link signal, reset to P_RST_VAL.
// Latency: 2 clk_100 cycles. No backpressure.
module spi_sync #(
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic clk_100,
    input  logic a_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            meta <= P_RST_VAL;
            q    <= P_RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_receiver.sv
// SPI slave receiver: oversamples SCK/MOSI/CS on clk_100 and emits words with valid/ready.
// Latency: 4 clk_100 cycles from the final sampling SCK pin edge to valid.
// Backpressure: a word completing while valid && !ready is dropped and overrun pulses.
module spi_receiver
    import spi_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_CS_POLAR   = 0,
    parameter int P_CPOL       = 0,
    parameter int P_CPHA       = 0,
    parameter int P_MSB_FIRST  = 1
) (
    input  logic                    clk_100,
    input  logic                    a_rst,
    input  logic                    SCK,
    input  logic                    MOSI,
    input  logic                    CS,
    output logic [P_DATA_WIDTH-1:0] data,
    output logic                    valid,
    input  logic                    ready,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int             CW          = $clog2(P_DATA_WIDTH + 1);
    localparam logic           CS_ACT      = (P_CS_POLAR != 0);
    localparam logic           SCK_IDLE    = (P_CPOL != 0);
    localparam logic           SAMPLE_RISE = mode_samples_rise(P_CPOL * 2 + P_CPHA);
    localparam logic [CW-1:0]  LAST_BIT    = CW'(P_DATA_WIDTH - 1);

    logic sck_s, mosi_s, cs_s, sck_d;
    logic cs_act, sample_edge;
    logic frame_start, frame_stop;
    logic word_done;
    logic [CW-1:0]           bit_cnt;
    logic [P_DATA_WIDTH-1:0] shreg, shreg_nxt;
    state_t                  state, state_nxt;

    spi_sync #(.P_RST_VAL(SCK_IDLE)) u_sync_sck  (.clk_100(clk_100), .a_rst(a_rst), .d(SCK),  .q(sck_s));
    spi_sync #(.P_RST_VAL(1'b0))     u_sync_mosi (.clk_100(clk_100), .a_rst(a_rst), .d(MOSI), .q(mosi_s));
    spi_sync #(.P_RST_VAL(~CS_ACT))  u_sync_cs   (.clk_100(clk_100), .a_rst(a_rst), .d(CS),   .q(cs_s));

    assign cs_act      = (cs_s == CS_ACT);
    assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_d) : (~sck_s & sck_d);

    generate
        if (P_MSB_FIRST != 0) begin : g_msb
            assign shreg_nxt = {shreg[P_DATA_WIDTH-2:0], mosi_s};
        end else begin : g_lsb
            assign shreg_nxt = {mosi_s, shreg[P_DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_stop  = 1'b0;
        case (state)
            IDLE: if (cs_act) begin
                state_nxt   = SHIFT;
                frame_start = 1'b1;
            end
            SHIFT: if (!cs_act) begin
                state_nxt  = IDLE;
                frame_stop = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The word is read from shreg one cycle after the final sample; the next
    // sampling edge is at least four clk_100 cycles away, so shreg is still intact.
    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            sck_d     <= SCK_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sck_d     <= sck_s;
            word_done <= 1'b0;
            frame_err <= 1'b0;
            if (frame_start) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (frame_stop) begin
                frame_err <= (bit_cnt != '0);
                bit_cnt   <= '0;
            end else if (state == SHIFT && sample_edge) begin
                shreg <= shreg_nxt;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end else begin
                    data  <= shreg;
                    valid <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_receiver.sv
// Directed bench for spi_receiver: mode 0 MSB-first instance plus a CPHA=1 LSB-first instance
// sharing SCK/MOSI/ready, each with its own chip select.
module tb_spi_receiver;

    logic       clk_100;
    logic       a_rst;
    logic       sck, mosi, ready;
    logic       cs0, cs1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, ov0, ov1, fe0, fe1;

    int checks   = 0;
    int failures = 0;
    int ov_cnt   = 0;
    int fe_cnt   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    spi_receiver #(
        .P_DATA_WIDTH(8), .P_CS_POLAR(0), .P_CPOL(0), .P_CPHA(0), .P_MSB_FIRST(1)
    ) u_dut0 (
        .clk_100(clk_100), .a_rst(a_rst), .SCK(sck), .MOSI(mosi), .CS(cs0),
        .data(data0), .valid(valid0), .ready(ready), .overrun(ov0), .frame_err(fe0)
    );

    spi_receiver #(
        .P_DATA_WIDTH(8), .P_CS_POLAR(0), .P_CPOL(0), .P_CPHA(1), .P_MSB_FIRST(0)
    ) u_dut1 (
        .clk_100(clk_100), .a_rst(a_rst), .SCK(sck), .MOSI(mosi), .CS(cs1),
        .data(data1), .valid(valid1), .ready(ready), .overrun(ov1), .frame_err(fe1)
    );

    initial clk_100 = 1'b0;
    always #5 clk_100 = ~clk_100;

    // Observe settled outputs just after each falling edge: handshakes and pulse counts.
    always @(negedge clk_100) begin
        #1;
        if (valid0 && ready) q0.push_back(data0);
        if (valid1 && ready) q1.push_back(data1);
        if (ov0 || ov1) ov_cnt++;
        if (fe0 || fe1) fe_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode 0: data set while SCK low, sampled on rising SCK; SCK period = 8 clk_100.
    task automatic bit_m0(input logic b);
        mosi = b;
        clks(4);
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    // CPHA=1, CPOL=0: data launched on rising SCK, sampled on falling SCK.
    task automatic bit_m1(input logic b);
        sck  = 1'b1;
        mosi = b;
        clks(4);
        sck = 1'b0;
        clks(4);
    endtask

    task automatic word_m0(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bit_m0(w[i]);
    endtask

    task automatic word_m1_lsb(input logic [7:0] w);
        for (int i = 0; i < 8; i++) bit_m1(w[i]);
    endtask

    initial begin
        logic [7:0] w;
        sck   = 1'b0;
        mosi  = 1'b0;
        cs0   = 1'b1;
        cs1   = 1'b1;
        ready = 1'b0;
        a_rst = 1'b0;
        clks(3);
        check("rst_data0",    data0,  8'h00);
        check("rst_valid0",   valid0, 1'b0);
        check("rst_overrun0", ov0,    1'b0);
        check("rst_frerr0",   fe0,    1'b0);
        check("rst_data1",    data1,  8'h00);
        check("rst_valid1",   valid1, 1'b0);
        a_rst = 1'b1;
        clks(4);

        // Single word 0xF0 with exact latency on the final sampling edge.
        ready = 1'b1;
        cs0   = 1'b0;
        clks(4);
        w = 8'hF0;
        for (int i = 7; i >= 1; i--) bit_m0(w[i]);
        mosi = w[0];
        clks(4);
        sck = 1'b1;
        clks(3);
        check("lat_valid_c3", valid0, 1'b0);
        clks(1);
        check("lat_valid_c4", valid0, 1'b1);
        check("f0_data",      data0,  8'hF0);
        clks(1);
        check("f0_valid_drop", valid0, 1'b0);
        clks(3);
        sck = 1'b0;
        clks(4);
        cs0 = 1'b1;
        clks(6);
        check("f0_no_frerr", fe_cnt, 0);

        // Back-to-back words inside one frame.
        q0.delete();
        cs0 = 1'b0;
        clks(4);
        word_m0(8'h3C);
        word_m0(8'hC3);
        clks(8);
        cs0 = 1'b1;
        clks(6);
        check("b2b_count",   q0.size(), 2);
        check("b2b_word0",   q0[0],     8'h3C);
        check("b2b_word1",   q0[1],     8'hC3);
        check("b2b_overrun", ov_cnt,    0);

        // Overrun: second word dropped while first is held.
        ready  = 1'b0;
        ov_cnt = 0;
        cs0    = 1'b0;
        clks(4);
        word_m0(8'hA5);
        word_m0(8'h5A);
        clks(8);
        check("ovr_data",  data0,  8'hA5);
        check("ovr_valid", valid0, 1'b1);
        check("ovr_pulse", ov_cnt, 1);
        q0.delete();
        ready = 1'b1;
        clks(3);
        check("ovr_consume_cnt", q0.size(), 1);
        check("ovr_consume_val", q0[0],     8'hA5);
        check("ovr_valid_drop",  valid0,    1'b0);
        cs0 = 1'b1;
        clks(6);

        // Frame abort after 5 bits, then a clean frame.
        fe_cnt = 0;
        q0.delete();
        cs0 = 1'b0;
        clks(4);
        for (int i = 0; i < 5; i++) bit_m0(1'b1);
        clks(4);
        cs0 = 1'b1;
        clks(6);
        check("abort_frerr", fe_cnt,    1);
        check("abort_valid", valid0,    1'b0);
        check("abort_noword", q0.size(), 0);
        cs0 = 1'b0;
        clks(4);
        word_m0(8'h81);
        clks(8);
        cs0 = 1'b1;
        clks(6);
        check("after_abort_cnt",   q0.size(), 1);
        check("after_abort_data",  q0[0],     8'h81);
        check("after_abort_frerr", fe_cnt,    1);

        // Reset mid-word while a word is held.
        ready = 1'b0;
        cs0   = 1'b0;
        clks(4);
        word_m0(8'h99);
        clks(6);
        check("pre_rst_valid", valid0, 1'b1);
        check("pre_rst_data",  data0,  8'h99);
        bit_m0(1'b1);
        bit_m0(1'b0);
        bit_m0(1'b1);
        a_rst = 1'b0;
        #1;
        check("mid_rst_data",    data0,  8'h00);
        check("mid_rst_valid",   valid0, 1'b0);
        check("mid_rst_overrun", ov0,    1'b0);
        check("mid_rst_frerr",   fe0,    1'b0);
        cs0 = 1'b1;
        clks(3);
        fe_cnt = 0;
        q0.delete();
        a_rst = 1'b1;
        clks(6);
        ready = 1'b1;
        cs0   = 1'b0;
        clks(4);
        word_m0(8'h66);
        clks(8);
        cs0 = 1'b1;
        clks(6);
        check("post_rst_cnt",   q0.size(), 1);
        check("post_rst_data",  q0[0],     8'h66);
        check("post_rst_frerr", fe_cnt,    0);

        // CPHA=1, LSB-first instance; mode-0 traffic must not have reached it.
        check("m1_idle_noword", q1.size(), 0);
        q0.delete();
        cs1 = 1'b0;
        clks(4);
        word_m1_lsb(8'h0F);
        clks(8);
        cs1 = 1'b1;
        clks(6);
        check("m1_cnt",     q1.size(), 1);
        check("m1_data",    q1[0],     8'h0F);
        check("m1_dut0_q",  q0.size(), 0);
        check("m1_frerr",   fe_cnt,    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
